mario_sprite_fetch: RTL and testbench
=====================================

Name: mario_sprite_fetch

Overview:
- Pixel-pipeline stage directly upstream of the Mario walk/stand/jump sprite ROMs; downstream of the VGA controller.
- Each pixel: tests DrawX/DrawY against Mario's 21x21 box and computes the ROM read address, horizontally mirrored when Mario faces left.
- Selects the animation frame with a vsync-driven FSM, registers the returned ROM colour, and flags the magenta key colour as transparent for the colour mapper.

Parameters:
- SPRITE_W, 21, sprite width in pixels
- SPRITE_H, 21, sprite height in pixels
- FRAMES_PER_STEP, 6, vsync frames per walk-animation step (>=1)
- ADDR_W, 9, ROM address width (ceil(log2(SPRITE_W*SPRITE_H)))

Ports:
- Clk  in  1  pixel/system clock
- Reset_n  in  1  asynchronous active-low reset
- vsync  in  1  VGA vsync, active low; falling edge = frame tick
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- pix_valid  in  1  DrawX/DrawY in active region
- MarioX  in  10  sprite top-left column, sampled on frame tick
- MarioY  in  10  sprite top-left row, sampled on frame tick
- walking  in  1  horizontal motion request, sampled on frame tick
- airborne  in  1  jump/fall state, sampled on frame tick
- facing_left  in  1  mirror request, sampled on frame tick
- rom_addr  out  ADDR_W  read_address to the sprite ROM bank
- frame_sel  out  3  ROM select: 0=stand, 1..4=walk_1..walk_4, 5=jump
- rom_color  in  24  output_color from the selected ROM (combinational)
- sprite_color  out  24  registered sprite pixel colour
- sprite_on  out  1  pixel inside box and not transparent
- sprite_valid  out  1  pix_valid delayed to align with sprite_color

Behaviour:
- Reset (async, Reset_n=0): all outputs 0; FSM=STAND; step counter=0; latched position/flags=0; vsync edge register=1.
- Frame tick: vsync registered; tick = prev 1, current 0. One-cycle pulse. On tick, latch MarioX, MarioY, walking, airborne and facing_left; these stay stable for the whole frame.
- FSM states STAND, WALK1, WALK2, WALK3, WALK4, JUMP. Transitions only on tick.
  - airborne=1 -> JUMP (priority over walking).
  - else walking=0 -> STAND and step counter cleared.
  - else from STAND/JUMP -> WALK1, counter=0.
  - else in WALKn: counter increments; at FRAMES_PER_STEP-1 it wraps to 0 and the FSM advances WALKn -> WALKn+1, WALK4 -> WALK1.
- frame_sel is the state encoding above, registered.
- Stage 1 (cycle N):
  - dx = DrawX - MarioX, dy = DrawY - MarioY, computed 11-bit signed.
  - in_box = pix_valid, 0<=dx<SPRITE_W, 0<=dy<SPRITE_H.
  - col = facing_left ? SPRITE_W-1-dx : dx.
  - rom_addr <= in_box ? dy*SPRITE_W + col : 0. Maximum is 440; the result never exceeds SPRITE_W*SPRITE_H-1.
  - in_box and pix_valid are registered.
- Stage 2 (cycle N+1):
  - sprite_color <= rom_color.
  - sprite_on <= in_box_q and (rom_color != 24'h800080).
  - sprite_valid <= pix_valid_q.
  - Total latency is 2 clocks from DrawX/DrawY to sprite_* outputs.
- Boundaries:
  - Box partly off-screen (MarioX>619 or MarioY>459): clipped naturally, no wrap.
  - DrawX<MarioX: negative dx, so not in box.
  - Tick coincident with an in-box pixel: the new position and state apply from the cycle after the tick.
  - Reset mid-frame: pipeline flushed, next outputs valid 2 clocks after first pix_valid post-reset.
  - walking drops mid-step: STAND at next tick.
  - FRAMES_PER_STEP=1: advances every tick.

Optional Feature:
- Macro MARIO_SPRITE_SCALE2X_EN.
- Defined: box is 2*SPRITE_W x 2*SPRITE_H. dx and dy are tested against doubled limits, then shifted right by 1 before mirroring and addressing. Rendered sprite is 42x42 with the same ROM contents.
- Undefined: 1:1 as above.

Decomposition:
- Package mario_pkg holds:
  - SPRITE_W, SPRITE_H, SPRITE_PIX=441
  - TRANSPARENT_KEY=24'h800080
  - enum anim_state_t {STAND=0, WALK1..WALK4, JUMP=5}, 3 bits
- Sub-module mario_anim_fsm: vsync edge detect, input latching, step counter, state register. Outputs frame_sel, tick and latched inputs.
- Top module holds the address pipeline.

Test Plan:
- MarioX=100, MarioY=200, facing_left=0; DrawX=105, DrawY=203 -> rom_addr=68 one clock later; sprite_on follows rom_color two clocks after the pixel.
- Same pixel with facing_left=1 (latched at tick) -> rom_addr=3*21+15=78.
- Pixels DrawX=99 and DrawX=121 at DrawY=200 -> sprite_on=0, rom_addr=0. DrawX=120, DrawY=220 -> rom_addr=440.
- rom_color=24'h800080 in box -> sprite_on=0, sprite_valid=1. rom_color=24'hF83800 -> sprite_on=1, sprite_color=24'hF83800.
- walking=1, FRAMES_PER_STEP=6, 30 vsync ticks -> frame_sel 1 for 6 ticks, then 2, 3, 4, 1. airborne=1 on next tick -> 5. Both low -> 0.
- Assert Reset_n=0 mid-frame while in WALK3 -> all outputs 0 immediately (async). After release, frame_sel=0 until the first tick with walking=1, then 1.

Source files
------------

// File: rtl/mario_pkg.sv
// Shared constants, animation state encoding and helpers for the Mario sprite fetch stage.
package mario_pkg;

  localparam int          SPRITE_W        = 21;
  localparam int          SPRITE_H        = 21;
  localparam int          SPRITE_PIX      = SPRITE_W * SPRITE_H;
  localparam logic [23:0] TRANSPARENT_KEY = 24'h800080;

  typedef enum logic [2:0] {
    STAND = 3'd0,
    WALK1 = 3'd1,
    WALK2 = 3'd2,
    WALK3 = 3'd3,
    WALK4 = 3'd4,
    JUMP  = 3'd5
  } anim_state_t;

  // Walk cycle successor; WALK4 loops back to WALK1.
  function automatic anim_state_t next_walk(input anim_state_t s);
    anim_state_t n;
    case (s)
      WALK1:   n = WALK2;
      WALK2:   n = WALK3;
      WALK3:   n = WALK4;
      WALK4:   n = WALK1;
      default: n = WALK1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mario_anim_fsm.sv
// Frame-tick detection, per-frame input latching and the walk/stand/jump animation FSM.
module mario_anim_fsm
  import mario_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vsync,
  input  logic [9:0] MarioX,
  input  logic [9:0] MarioY,
  input  logic       walking,
  input  logic       airborne,
  input  logic       facing_left,
  output logic [2:0] frame_sel,
  output logic [9:0] mario_x,
  output logic [9:0] mario_y,
  output logic       face_left
);

  localparam int             CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic              vsync_r;
  logic              tick_s;
  anim_state_t       state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [9:0]        mario_x_r, mario_y_r;
  logic              face_left_r;

  assign tick_s = vsync_r & ~vsync;

  // Vsync history, per-frame input latches, step counter and state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vsync_r     <= 1'b1;
      state_r     <= STAND;
      cnt_r       <= '0;
      mario_x_r   <= 10'd0;
      mario_y_r   <= 10'd0;
      face_left_r <= 1'b0;
    end else begin
      vsync_r <= vsync;
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (tick_s) begin
        mario_x_r   <= MarioX;
        mario_y_r   <= MarioY;
        face_left_r <= facing_left;
      end else begin
        mario_x_r   <= mario_x_r;
        mario_y_r   <= mario_y_r;
        face_left_r <= face_left_r;
      end
    end
  end

  // Next animation state; airborne outranks walking, and nothing moves between ticks.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (tick_s) begin
      if (airborne) begin
        state_s = JUMP;
        cnt_s   = '0;
      end else if (!walking) begin
        state_s = STAND;
        cnt_s   = '0;
      end else begin
        case (state_r)
          STAND, JUMP: begin
            state_s = WALK1;
            cnt_s   = '0;
          end
          default: begin
            if (cnt_r == CNT_LAST) begin
              cnt_s   = '0;
              state_s = next_walk(state_r);
            end else begin
              cnt_s   = cnt_r + CNT_W'(1);
              state_s = state_r;
            end
          end
        endcase
      end
    end else begin
      state_s = state_r;
      cnt_s   = cnt_r;
    end
  end

  assign frame_sel = state_r;
  assign mario_x   = mario_x_r;
  assign mario_y   = mario_y_r;
  assign face_left = face_left_r;

endmodule

// File: rtl/mario_sprite_fetch.sv
// Two-stage sprite address/colour pipeline between the VGA controller and the Mario ROMs.
// Define MARIO_SPRITE_SCALE2X_EN to render the sprite at 2x (42x42) from the same ROM data.
module mario_sprite_fetch #(
  parameter int SPRITE_W        = mario_pkg::SPRITE_W,
  parameter int SPRITE_H        = mario_pkg::SPRITE_H,
  parameter int FRAMES_PER_STEP = 6,
  parameter int ADDR_W          = 9
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vsync,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid,
  input  logic [9:0]        MarioX,
  input  logic [9:0]        MarioY,
  input  logic              walking,
  input  logic              airborne,
  input  logic              facing_left,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [2:0]        frame_sel,
  input  logic [23:0]       rom_color,
  output logic [23:0]       sprite_color,
  output logic              sprite_on,
  output logic              sprite_valid
);

  import mario_pkg::*;

`ifdef MARIO_SPRITE_SCALE2X_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif

  localparam logic [9:0]        BOX_W  = 10'(SPRITE_W << SCALE_SH);
  localparam logic [9:0]        BOX_H  = 10'(SPRITE_H << SCALE_SH);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(SPRITE_W);
  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(SPRITE_W - 1);

  logic [9:0]        mario_x_s, mario_y_s;
  logic              face_left_s;
  logic [10:0]       dx_s, dy_s;
  logic              in_box_s;
  logic [ADDR_W-1:0] cx_s, ry_s, col_s, addr_s;
  logic              in_box_q_r, pix_valid_q_r;

  mario_anim_fsm #(
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_anim (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .vsync       (vsync),
    .MarioX      (MarioX),
    .MarioY      (MarioY),
    .walking     (walking),
    .airborne    (airborne),
    .facing_left (facing_left),
    .frame_sel   (frame_sel),
    .mario_x     (mario_x_s),
    .mario_y     (mario_y_s),
    .face_left   (face_left_s)
  );

  // 11-bit differences keep the sign, so pixels left of/above the box never wrap into it.
  assign dx_s     = {1'b0, DrawX} - {1'b0, mario_x_s};
  assign dy_s     = {1'b0, DrawY} - {1'b0, mario_y_s};
  assign in_box_s = pix_valid & ~dx_s[10] & ~dy_s[10] & (dx_s[9:0] < BOX_W) & (dy_s[9:0] < BOX_H);
  assign cx_s     = ADDR_W'(dx_s[9:0] >> SCALE_SH);
  assign ry_s     = ADDR_W'(dy_s[9:0] >> SCALE_SH);

  // Mirror the ROM column when facing left and form the row-major ROM address.
  always_comb begin
    col_s  = cx_s;
    addr_s = '0;
    if (face_left_s) begin
      col_s = W_LAST - cx_s;
    end else begin
      col_s = cx_s;
    end
    if (in_box_s) begin
      addr_s = ry_s * W_A + col_s;
    end else begin
      addr_s = '0;
    end
  end

  // Stage 1: ROM address plus the box and valid flags that travel alongside it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr      <= '0;
      in_box_q_r    <= 1'b0;
      pix_valid_q_r <= 1'b0;
    end else begin
      rom_addr      <= addr_s;
      in_box_q_r    <= in_box_s;
      pix_valid_q_r <= pix_valid;
    end
  end

  // Stage 2: capture the ROM colour and drop the magenta key.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sprite_color <= 24'h000000;
      sprite_on    <= 1'b0;
      sprite_valid <= 1'b0;
    end else begin
      sprite_color <= rom_color;
      sprite_on    <= in_box_q_r & (rom_color != TRANSPARENT_KEY);
      sprite_valid <= pix_valid_q_r;
    end
  end

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Self-checking bench for mario_sprite_fetch: directed plan items plus randomized pixels/frames vs a reference model.
module tb_mario_sprite_fetch;

  localparam int          FPS = 6;
  localparam logic [23:0] KEY = 24'h800080;
`ifdef MARIO_SPRITE_SCALE2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n, vsync, pix_valid, walking, airborne, facing_left;
  logic [9:0]  DrawX, DrawY, MarioX, MarioY;
  logic [8:0]  rom_addr, rom_addr1;
  logic [2:0]  frame_sel, frame_sel1;
  logic [23:0] rom_color, rom_color1, sprite_color, sprite_color1;
  logic        sprite_on, sprite_valid, sprite_on1, sprite_valid1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int lx, ly, mode, wticks, e_addr, e_frame, e_frame1;
  bit lf, vprev, e_inbox, e_pv, e_on, e_valid;
  logic [23:0] e_color;

  always #5 Clk = ~Clk;

  function automatic logic [23:0] rom_fn(input int a, input int f);
    logic [23:0] c;
    if (a % 5 == 3)      c = KEY;
    else if (a % 5 == 0) c = 24'hF83800;
    else                 c = {8'(a), 5'(f), 11'(a * 7)};
    return c;
  endfunction

  assign rom_color  = rom_fn(int'(rom_addr), int'(frame_sel));
  assign rom_color1 = rom_fn(int'(rom_addr1), int'(frame_sel1));

  mario_sprite_fetch #(.FRAMES_PER_STEP(FPS)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vsync(vsync), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid), .MarioX(MarioX), .MarioY(MarioY), .walking(walking),
    .airborne(airborne), .facing_left(facing_left), .rom_addr(rom_addr),
    .frame_sel(frame_sel), .rom_color(rom_color), .sprite_color(sprite_color),
    .sprite_on(sprite_on), .sprite_valid(sprite_valid)
  );

  mario_sprite_fetch #(.FRAMES_PER_STEP(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .vsync(vsync), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid), .MarioX(MarioX), .MarioY(MarioY), .walking(walking),
    .airborne(airborne), .facing_left(facing_left), .rom_addr(rom_addr1),
    .frame_sel(frame_sel1), .rom_color(rom_color1), .sprite_color(sprite_color1),
    .sprite_on(sprite_on1), .sprite_valid(sprite_valid1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Animation frame from how many consecutive walking ticks have been seen.
  function automatic int anim_frame(input int fps);
    if (mode == 2) return 5;
    if (mode == 0) return 0;
    return 1 + ((wticks - 1) / fps) % 4;
  endfunction

  task automatic model_reset();
    lx = 0; ly = 0; lf = 1'b0; mode = 0; wticks = 0; vprev = 1'b1;
    e_addr = 0; e_inbox = 1'b0; e_pv = 1'b0; e_on = 1'b0; e_valid = 1'b0;
    e_color = 24'h000000; e_frame = 0; e_frame1 = 0;
  endtask

  task automatic check_zero();
    check_val("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_val("rst_frame_sel", 32'(frame_sel), 32'd0);
    check_val("rst_sprite_color", 32'(sprite_color), 32'd0);
    check_val("rst_sprite_on", 32'(sprite_on), 32'd0);
    check_val("rst_sprite_valid", 32'(sprite_valid), 32'd0);
    check_val("rst_frame_sel_fps1", 32'(frame_sel1), 32'd0);
  endtask

  // Advance the model over one clock edge using the applied inputs, then compare.
  task automatic cycle();
    int dx, dy;
    bit inb;
    logic [23:0] c;
    c       = rom_fn(e_addr, e_frame);
    e_color = c;
    e_on    = e_inbox && (c != KEY);
    e_valid = e_pv;
    dx  = int'(DrawX) - lx;
    dy  = int'(DrawY) - ly;
    inb = pix_valid && dx >= 0 && dx < 21 * SC && dy >= 0 && dy < 21 * SC;
    e_addr  = inb ? (dy / SC) * 21 + (lf ? 20 - dx / SC : dx / SC) : 0;
    e_inbox = inb;
    e_pv    = pix_valid;
    if (vprev && !vsync) begin
      lx = int'(MarioX); ly = int'(MarioY); lf = facing_left;
      if (airborne)      begin mode = 2; wticks = 0; end
      else if (!walking) begin mode = 0; wticks = 0; end
      else               begin mode = 1; wticks++;   end
    end
    vprev    = vsync;
    e_frame  = anim_frame(FPS);
    e_frame1 = anim_frame(1);
    @(posedge Clk); #1;
    check_val("rom_addr", 32'(rom_addr), 32'(e_addr));
    check_val("frame_sel", 32'(frame_sel), 32'(e_frame));
    check_val("frame_sel_fps1", 32'(frame_sel1), 32'(e_frame1));
    check_val("sprite_color", 32'(sprite_color), 32'(e_color));
    check_val("sprite_on", 32'(sprite_on), 32'(e_on));
    check_val("sprite_valid", 32'(sprite_valid), 32'(e_valid));
  endtask

  task automatic frame(input int gap);
    vsync = 1'b0;
    repeat (2) cycle();
    vsync = 1'b1;
    repeat (gap) cycle();
  endtask

  task automatic put_pix(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1;
    cycle();
    pix_valid = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b1; vsync = 1'b1; pix_valid = 1'b0; walking = 1'b0; airborne = 1'b0;
    facing_left = 1'b0; DrawX = 10'd0; DrawY = 10'd0; MarioX = 10'd0; MarioY = 10'd0;
    model_reset();
    #1 Reset_n = 1'b0;
    #2 check_zero();
    @(posedge Clk); @(posedge Clk); #1;
    Reset_n = 1'b1;

    // Directed pixel/address/colour cases.
    MarioX = 10'd100; MarioY = 10'd200;
    frame(3);
`ifndef MARIO_SPRITE_SCALE2X_EN
    put_pix(105, 203); check_val("addr_68", 32'(rom_addr), 32'd68);
    cycle();           check_val("key_on", 32'(sprite_on), 32'd0);
                       check_val("key_valid", 32'(sprite_valid), 32'd1);
    put_pix(120, 220); check_val("addr_440", 32'(rom_addr), 32'd440);
    cycle();           check_val("opaque_on", 32'(sprite_on), 32'd1);
                       check_val("opaque_color", 32'(sprite_color), 32'hF83800);
    put_pix(99, 200);  check_val("addr_left_out", 32'(rom_addr), 32'd0);
    put_pix(121, 200); check_val("addr_right_out", 32'(rom_addr), 32'd0);
                       check_val("left_out_on", 32'(sprite_on), 32'd0);
    facing_left = 1'b1;
    frame(3);
    put_pix(105, 203); check_val("addr_mirror_78", 32'(rom_addr), 32'd78);
`else
    put_pix(105, 203); put_pix(141, 241); put_pix(99, 200); put_pix(142, 200);
    facing_left = 1'b1;
    frame(3);
    put_pix(105, 203);
`endif
    cycle();

    // Walk animation over 30 ticks, then jump, then stand.
    facing_left = 1'b0; walking = 1'b1;
    for (int i = 0; i < 30; i++) frame(2);
    check_val("walk_30_ticks", 32'(frame_sel), 32'd1);
    airborne = 1'b1; frame(2);
    check_val("jump", 32'(frame_sel), 32'd5);
    airborne = 1'b0; walking = 1'b0; frame(2);
    check_val("stand", 32'(frame_sel), 32'd0);

    // Reach WALK3, then reset asynchronously mid-frame with pixels in flight.
    walking = 1'b1;
    for (int i = 0; i < 13; i++) frame(1);
    check_val("walk3", 32'(frame_sel), 32'd3);
    DrawX = 10'd105; DrawY = 10'd203; pix_valid = 1'b1;
    cycle();
    #3 Reset_n = 1'b0;
    #1 check_zero();
    model_reset();
    pix_valid = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (3) cycle();
    frame(2);
    check_val("walk1_after_reset", 32'(frame_sel), 32'd1);

    // Randomized pixels around the sprite with random frame ticks and control inputs.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        MarioX      = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(600, 639)) : 10'($urandom_range(0, 639));
        MarioY      = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(440, 479)) : 10'($urandom_range(0, 479));
        walking     = ($urandom_range(0, 3) != 0);
        airborne    = ($urandom_range(0, 4) == 0);
        facing_left = 1'($urandom_range(0, 1));
        pix_valid   = 1'($urandom_range(0, 1));
        frame(1);
      end else begin
        DrawX     = 10'(int'(MarioX) + $urandom_range(0, 50) - 4);
        DrawY     = 10'(int'(MarioY) + $urandom_range(0, 50) - 4);
        pix_valid = ($urandom_range(0, 7) != 0);
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
